// File: rtl/tlb_pkg.sv
// Shared constants, op encodings and CSR field helpers for the TLB op controller.
package tlb_pkg;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IDXW   = $clog2(TLBNUM);

   typedef enum logic [2:0] {
      OP_SRCH = 3'd0,
      OP_RD   = 3'd1,
      OP_WR   = 3'd2,
      OP_FILL = 3'd3,
      OP_INV  = 3'd4
   } tlb_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } tlb_state_e;

   localparam logic [4:0] INVOP_MAX  = 5'd6;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;
   localparam logic [5:0] PS_4K      = 6'd12;
   localparam logic [5:0] PS_4M      = 6'd22;

   localparam int unsigned TLBIDX_NE    = 31;
   localparam int unsigned TLBIDX_PS_LO = 24;
   localparam int unsigned ELO_V        = 0;
   localparam int unsigned ELO_D        = 1;
   localparam int unsigned ELO_PLV_LO   = 2;
   localparam int unsigned ELO_MAT_LO   = 4;
   localparam int unsigned ELO_G        = 6;
   localparam int unsigned ELO_PPN_LO   = 8;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_page_t;

   function automatic tlb_page_t elo_to_page(input logic [31:0] elo);
      tlb_page_t p;
      p.ppn = elo[ELO_PPN_LO +: 20];
      p.plv = elo[ELO_PLV_LO +: 2];
      p.mat = elo[ELO_MAT_LO +: 2];
      p.d   = elo[ELO_D];
      p.v   = elo[ELO_V];
      return p;
   endfunction

   function automatic logic [31:0] page_to_elo(input tlb_page_t p, input logic g);
      return {4'b0, p.ppn, 1'b0, g, p.mat, p.plv, p.d, p.v};
   endfunction

endpackage

// File: rtl/tlb_fill_idx.sv
// Free-running fill index source used by TLBFILL; kept separate so an LFSR can drop in.
module tlb_fill_idx
   import tlb_pkg::*;
#(
   parameter  int unsigned TLBNUM = tlb_pkg::TLBNUM,
   localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   output logic [IDXW-1:0] fill_idx
);

   localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fill_idx <= '0;
      else if (fill_idx == LAST)
         fill_idx <= '0;
      else
         fill_idx <= fill_idx + 1'b1;
   end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB ports and
// returns results as a single-cycle CSR write-back bundle.
module tlb_op_ctrl
   import tlb_pkg::*;
#(
   parameter  int unsigned TLBNUM = tlb_pkg::TLBNUM,
   localparam int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [4:0]      req_invop,
   input  logic [9:0]      req_asid,
   input  logic [18:0]     req_vppn,
   input  logic            flush,
   input  logic [31:0]     csr_tlbidx,
   input  logic [18:0]     csr_tlbehi,
   input  logic [31:0]     csr_elo0,
   input  logic [31:0]     csr_elo1,
   input  logic [9:0]      csr_asid,
   input  logic [5:0]      csr_ecode,
   output logic            srch_act,
   output logic [18:0]     s_vppn,
   output logic [9:0]      s_asid,
   input  logic            s_found,
   input  logic [IDXW-1:0] s_idx,
   output logic            tlb_we,
   output logic [IDXW-1:0] w_idx,
   output logic            w_e,
   output logic [18:0]     w_vppn,
   output logic [5:0]      w_ps,
   output logic [9:0]      w_asid,
   output logic            w_g,
   output logic [19:0]     w_ppn0,
   output logic [1:0]      w_plv0,
   output logic [1:0]      w_mat0,
   output logic            w_d0,
   output logic            w_v0,
   output logic [19:0]     w_ppn1,
   output logic [1:0]      w_plv1,
   output logic [1:0]      w_mat1,
   output logic            w_d1,
   output logic            w_v1,
   output logic [IDXW-1:0] r_idx,
   input  logic            r_e,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   input  logic [9:0]      r_asid,
   input  logic            r_g,
   input  logic [19:0]     r_ppn0,
   input  logic [1:0]      r_plv0,
   input  logic [1:0]      r_mat0,
   input  logic            r_d0,
   input  logic            r_v0,
   input  logic [19:0]     r_ppn1,
   input  logic [1:0]      r_plv1,
   input  logic [1:0]      r_mat1,
   input  logic            r_d1,
   input  logic            r_v1,
   output logic            inv_valid,
   output logic [4:0]      inv_op,
   output logic [9:0]      inv_asid,
   output logic [18:0]     inv_vppn,
   output logic            csr_we,
   output logic [4:0]      csr_wsel,
   output logic [31:0]     csr_wtlbidx,
   output logic [18:0]     csr_wehi,
   output logic [31:0]     csr_welo0,
   output logic [31:0]     csr_welo1,
   output logic [9:0]      csr_wasid,
   output logic            done,
   output logic            inv_err
);

   localparam logic [4:0] WSEL_IDX = 5'b00001;
   localparam logic [4:0] WSEL_ALL = 5'b11111;

   tlb_state_e      state_q, state_d;
   tlb_op_e         op_q;
   logic [4:0]      invop_q;
   logic [9:0]      asid_q;
   logic [18:0]     vppn_q;
   logic            found_q;
   logic [IDXW-1:0] sidx_q;
   logic            rd_e_q;
   logic [18:0]     rd_vppn_q;
   logic [5:0]      rd_ps_q;
   logic [9:0]      rd_asid_q;
   logic            rd_g_q;
   tlb_page_t       rd_p0_q, rd_p1_q;

   logic [IDXW-1:0] fill_idx;
   logic            idx_ne;
   logic [5:0]      idx_ps;
   logic [IDXW-1:0] idx_index;
   tlb_page_t       elo0_page, elo1_page;
   logic            unused_bits;

   assign idx_ne    = csr_tlbidx[TLBIDX_NE];
   assign idx_ps    = csr_tlbidx[TLBIDX_PS_LO +: 6];
   assign idx_index = csr_tlbidx[IDXW-1:0];
   assign elo0_page = elo_to_page(csr_elo0);
   assign elo1_page = elo_to_page(csr_elo1);
   assign unused_bits = ^{csr_elo0[31:28], csr_elo0[7], csr_elo1[31:28], csr_elo1[7]};

   tlb_fill_idx #(.TLBNUM(TLBNUM)) u_fill_idx (
      .clk      (clk),
      .reset    (reset),
      .fill_idx (fill_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_SRCH;
         invop_q   <= '0;
         asid_q    <= '0;
         vppn_q    <= '0;
         found_q   <= 1'b0;
         sidx_q    <= '0;
         rd_e_q    <= 1'b0;
         rd_vppn_q <= '0;
         rd_ps_q   <= '0;
         rd_asid_q <= '0;
         rd_g_q    <= 1'b0;
         rd_p0_q   <= '0;
         rd_p1_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && req_valid) begin
            op_q    <= tlb_op_e'(req_op);
            invop_q <= req_invop;
            asid_q  <= req_asid;
            vppn_q  <= req_vppn;
         end
         if (state_q == ST_EXEC && op_q == OP_SRCH) begin
            found_q <= s_found;
            sidx_q  <= s_idx;
         end
         if (state_q == ST_EXEC && op_q == OP_RD) begin
            rd_e_q    <= r_e;
            rd_vppn_q <= r_vppn;
            rd_ps_q   <= r_ps;
            rd_asid_q <= r_asid;
            rd_g_q    <= r_g;
            rd_p0_q   <= '{ppn: r_ppn0, plv: r_plv0, mat: r_mat0, d: r_d0, v: r_v0};
            rd_p1_q   <= '{ppn: r_ppn1, plv: r_plv1, mat: r_mat1, d: r_d1, v: r_v1};
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      req_ready   = 1'b0;
      srch_act    = 1'b0;
      s_vppn      = '0;
      s_asid      = '0;
      tlb_we      = 1'b0;
      w_idx       = '0;
      w_e         = 1'b0;
      w_vppn      = '0;
      w_ps        = '0;
      w_asid      = '0;
      w_g         = 1'b0;
      w_ppn0      = '0;
      w_plv0      = '0;
      w_mat0      = '0;
      w_d0        = 1'b0;
      w_v0        = 1'b0;
      w_ppn1      = '0;
      w_plv1      = '0;
      w_mat1      = '0;
      w_d1        = 1'b0;
      w_v1        = 1'b0;
      r_idx       = '0;
      inv_valid   = 1'b0;
      inv_op      = '0;
      inv_asid    = '0;
      inv_vppn    = '0;
      csr_we      = 1'b0;
      csr_wsel    = '0;
      csr_wtlbidx = '0;
      csr_wehi    = '0;
      csr_welo0   = '0;
      csr_welo1   = '0;
      csr_wasid   = '0;
      done        = 1'b0;
      inv_err     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = flush ? ST_IDLE : ST_RESP;
            // A flushed op must leave no side effect on the TLB.
            if (!flush) begin
               case (op_q)
                  OP_SRCH: begin
                     srch_act = 1'b1;
                     s_vppn   = csr_tlbehi;
                     s_asid   = csr_asid;
                  end
                  OP_RD: r_idx = idx_index;
                  OP_WR, OP_FILL: begin
                     tlb_we = 1'b1;
                     w_idx  = (op_q == OP_WR) ? idx_index : fill_idx;
                     w_e    = (csr_ecode == ECODE_TLBR) ? 1'b1 : ~idx_ne;
                     w_vppn = csr_tlbehi;
                     w_ps   = idx_ps;
                     w_asid = csr_asid;
                     w_g    = csr_elo0[ELO_G] & csr_elo1[ELO_G];
                     w_ppn0 = elo0_page.ppn;
                     w_plv0 = elo0_page.plv;
                     w_mat0 = elo0_page.mat;
                     w_d0   = elo0_page.d;
                     w_v0   = elo0_page.v;
                     w_ppn1 = elo1_page.ppn;
                     w_plv1 = elo1_page.plv;
                     w_mat1 = elo1_page.mat;
                     w_d1   = elo1_page.d;
                     w_v1   = elo1_page.v;
                  end
                  OP_INV: begin
                     if (invop_q <= INVOP_MAX) begin
                        inv_valid = 1'b1;
                        inv_op    = invop_q;
                        inv_asid  = asid_q;
                        inv_vppn  = vppn_q;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (!flush) begin
               done = 1'b1;
               case (op_q)
                  OP_SRCH: begin
                     csr_we                 = 1'b1;
                     csr_wsel               = WSEL_IDX;
                     csr_wtlbidx            = csr_tlbidx;
                     csr_wtlbidx[TLBIDX_NE] = ~found_q;
                     if (found_q)
                        csr_wtlbidx[IDXW-1:0] = sidx_q;
                  end
                  OP_RD: begin
                     csr_we      = 1'b1;
                     csr_wsel    = WSEL_ALL;
                     csr_wtlbidx = csr_tlbidx;
                     if (rd_e_q) begin
                        csr_wtlbidx[TLBIDX_NE]           = 1'b0;
                        csr_wtlbidx[TLBIDX_PS_LO +: 6]   = rd_ps_q;
                        csr_wehi                         = rd_vppn_q;
                        csr_welo0                        = page_to_elo(rd_p0_q, rd_g_q);
                        csr_welo1                        = page_to_elo(rd_p1_q, rd_g_q);
                        csr_wasid                        = rd_asid_q;
                     end else begin
                        csr_wtlbidx[TLBIDX_NE]         = 1'b1;
                        csr_wtlbidx[TLBIDX_PS_LO +: 6] = '0;
                     end
                  end
                  OP_INV: inv_err = (invop_q > INVOP_MAX);
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a small behavioural TLB behind the search/read/write ports.
module tb_tlb_op_ctrl;

   localparam logic [2:0] SRCH = 3'd0, RD = 3'd1, WR = 3'd2, FILL = 3'd3, INV = 3'd4;

   logic        clk, reset, req_valid, req_ready, flush;
   logic [2:0]  req_op;
   logic [4:0]  req_invop;
   logic [9:0]  req_asid;
   logic [18:0] req_vppn;
   logic [31:0] csr_tlbidx, csr_elo0, csr_elo1;
   logic [18:0] csr_tlbehi;
   logic [9:0]  csr_asid;
   logic [5:0]  csr_ecode;
   logic        srch_act, s_found;
   logic [18:0] s_vppn;
   logic [9:0]  s_asid;
   logic [3:0]  s_idx, w_idx, r_idx;
   logic        tlb_we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
   logic [18:0] w_vppn;
   logic [5:0]  w_ps;
   logic [9:0]  w_asid;
   logic [19:0] w_ppn0, w_ppn1;
   logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
   logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
   logic        inv_valid, csr_we, done, inv_err;
   logic [4:0]  inv_op, csr_wsel;
   logic [9:0]  inv_asid, csr_wasid;
   logic [18:0] inv_vppn, csr_wehi;
   logic [31:0] csr_wtlbidx, csr_welo0, csr_welo1;

   int vec  = 0;
   int miss = 0;
   int clk_cnt;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0, mat0;
      logic        d0, v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1, mat1;
      logic        d1, v1;
   } ent_t;

   ent_t tlb_m [16] = '{default: '0};

   tlb_op_ctrl #(.TLBNUM(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_invop(req_invop), .req_asid(req_asid), .req_vppn(req_vppn),
      .flush(flush), .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi),
      .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_asid(csr_asid), .csr_ecode(csr_ecode),
      .srch_act(srch_act), .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_idx(s_idx),
      .tlb_we(tlb_we), .w_idx(w_idx), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
      .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0),
      .w_d0(w_d0), .w_v0(w_v0), .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1),
      .w_d1(w_d1), .w_v1(w_v1), .r_idx(r_idx), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps),
      .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0),
      .r_d0(r_d0), .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1),
      .r_d1(r_d1), .r_v1(r_v1), .inv_valid(inv_valid), .inv_op(inv_op),
      .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_we(csr_we), .csr_wsel(csr_wsel),
      .csr_wtlbidx(csr_wtlbidx), .csr_wehi(csr_wehi), .csr_welo0(csr_welo0),
      .csr_welo1(csr_welo1), .csr_wasid(csr_wasid), .done(done), .inv_err(inv_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) clk_cnt <= 0;
      else       clk_cnt <= clk_cnt + 1;
   end

   // Behavioural TLB: write on clock, combinational search and read.
   always @(posedge clk) begin
      if (tlb_we)
         tlb_m[w_idx] <= '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                           ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                           ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};
   end

   always_comb begin
      s_found = 1'b0;
      s_idx   = '0;
      for (int i = 0; i < 16; i++) begin
         if (tlb_m[i].e && tlb_m[i].vppn == s_vppn && (tlb_m[i].g || tlb_m[i].asid == s_asid)) begin
            s_found = 1'b1;
            s_idx   = i[3:0];
         end
      end
   end

   assign r_e    = tlb_m[r_idx].e;
   assign r_vppn = tlb_m[r_idx].vppn;
   assign r_ps   = tlb_m[r_idx].ps;
   assign r_asid = tlb_m[r_idx].asid;
   assign r_g    = tlb_m[r_idx].g;
   assign r_ppn0 = tlb_m[r_idx].ppn0;
   assign r_plv0 = tlb_m[r_idx].plv0;
   assign r_mat0 = tlb_m[r_idx].mat0;
   assign r_d0   = tlb_m[r_idx].d0;
   assign r_v0   = tlb_m[r_idx].v0;
   assign r_ppn1 = tlb_m[r_idx].ppn1;
   assign r_plv1 = tlb_m[r_idx].plv1;
   assign r_mat1 = tlb_m[r_idx].mat1;
   assign r_d1   = tlb_m[r_idx].d1;
   assign r_v1   = tlb_m[r_idx].v1;

   // Presents a request in IDLE and returns at the falling edge inside EXEC.
   task automatic begin_op(input logic [2:0] op, input logic [4:0] iop,
                           input logic [9:0] asid, input logic [18:0] vppn);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_invop = iop;
      req_asid  = asid;
      req_vppn  = vppn;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_invop = '0; req_asid = '0;
      req_vppn = '0; flush = 1'b0; csr_tlbidx = '0; csr_tlbehi = '0; csr_elo0 = '0;
      csr_elo1 = '0; csr_asid = '0; csr_ecode = '0;
      @(negedge clk);
      vec++; if (req_ready !== 1'b1) begin miss++; $display("FAIL rst_ready: got %h want 1", req_ready); end
      vec++; if ({done, csr_we, tlb_we, srch_act, inv_valid, inv_err} !== 6'b0) begin miss++; $display("FAIL rst_strobes: got %b want 000000", {done, csr_we, tlb_we, srch_act, inv_valid, inv_err}); end
      vec++; if ({r_idx, w_idx, csr_wsel, csr_wtlbidx} !== '0) begin miss++; $display("FAIL rst_data: got %h want 0", {r_idx, w_idx, csr_wsel, csr_wtlbidx}); end
      reset = 1'b0;
   endtask

   task automatic test_write_search();
      csr_tlbidx = 32'h0C00_0005; csr_tlbehi = 19'h12345; csr_asid = 10'd3;
      csr_elo0 = 32'h000A_BC1F; csr_elo1 = 32'h000A_BD11; csr_ecode = 6'h00;
      begin_op(WR, 5'd0, 10'd0, 19'd0);
      vec++; if (req_ready !== 1'b0) begin miss++; $display("FAIL wr_busy: got %h want 0", req_ready); end
      vec++; if ({tlb_we, w_idx, w_e} !== {1'b1, 4'd5, 1'b1}) begin miss++; $display("FAIL wr_port: got %h want %h", {tlb_we, w_idx, w_e}, {1'b1, 4'd5, 1'b1}); end
      vec++; if ({w_vppn, w_asid, w_ps, w_g} !== {19'h12345, 10'd3, 6'd12, 1'b0}) begin miss++; $display("FAIL wr_key: got %h want %h", {w_vppn, w_asid, w_ps, w_g}, {19'h12345, 10'd3, 6'd12, 1'b0}); end
      vec++; if ({w_ppn0, w_mat0, w_plv0, w_d0, w_v0} !== {20'hABC, 2'd1, 2'd3, 1'b1, 1'b1}) begin miss++; $display("FAIL wr_page0: got %h want %h", {w_ppn0, w_mat0, w_plv0, w_d0, w_v0}, {20'hABC, 2'd1, 2'd3, 1'b1, 1'b1}); end
      vec++; if ({w_ppn1, w_mat1, w_plv1, w_d1, w_v1} !== {20'hABD, 2'd1, 2'd0, 1'b0, 1'b1}) begin miss++; $display("FAIL wr_page1: got %h want %h", {w_ppn1, w_mat1, w_plv1, w_d1, w_v1}, {20'hABD, 2'd1, 2'd0, 1'b0, 1'b1}); end
      @(negedge clk);
      vec++; if ({done, csr_we, tlb_we} !== 3'b100) begin miss++; $display("FAIL wr_resp: got %b want 100", {done, csr_we, tlb_we}); end
      csr_tlbidx = 32'h8C00_0000;
      begin_op(SRCH, 5'd0, 10'd0, 19'd0);
      vec++; if ({srch_act, s_vppn, s_asid} !== {1'b1, 19'h12345, 10'd3}) begin miss++; $display("FAIL srch_key: got %h want %h", {srch_act, s_vppn, s_asid}, {1'b1, 19'h12345, 10'd3}); end
      vec++; if (done !== 1'b0) begin miss++; $display("FAIL srch_early_done: got %h want 0", done); end
      @(negedge clk);
      vec++; if ({done, csr_we, csr_wsel} !== {1'b1, 1'b1, 5'b00001}) begin miss++; $display("FAIL srch_hit_strobe: got %h want %h", {done, csr_we, csr_wsel}, {1'b1, 1'b1, 5'b00001}); end
      vec++; if (csr_wtlbidx !== 32'h0C00_0005) begin miss++; $display("FAIL srch_hit_idx: got %h want 0c000005", csr_wtlbidx); end
      @(negedge clk);
      vec++; if ({done, csr_we, req_ready} !== 3'b001) begin miss++; $display("FAIL srch_after: got %b want 001", {done, csr_we, req_ready}); end
   endtask

   task automatic test_search_miss();
      csr_asid = 10'd4; csr_tlbidx = 32'h0C00_0007;
      begin_op(SRCH, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      vec++; if ({done, csr_we, csr_wsel} !== {1'b1, 1'b1, 5'b00001}) begin miss++; $display("FAIL miss_strobe: got %h want %h", {done, csr_we, csr_wsel}, {1'b1, 1'b1, 5'b00001}); end
      vec++; if (csr_wtlbidx !== 32'h8C00_0007) begin miss++; $display("FAIL miss_idx: got %h want 8c000007", csr_wtlbidx); end
      csr_asid = 10'd3;
   endtask

   task automatic test_read();
      csr_tlbidx = 32'h0000_0005;
      begin_op(RD, 5'd0, 10'd0, 19'd0);
      vec++; if (r_idx !== 4'd5) begin miss++; $display("FAIL rd_idx: got %h want 5", r_idx); end
      @(negedge clk);
      vec++; if ({done, csr_we, csr_wsel} !== {1'b1, 1'b1, 5'b11111}) begin miss++; $display("FAIL rd_strobe: got %h want %h", {done, csr_we, csr_wsel}, {1'b1, 1'b1, 5'b11111}); end
      vec++; if ({csr_wtlbidx, csr_wehi, csr_wasid} !== {32'h0C00_0005, 19'h12345, 10'd3}) begin miss++; $display("FAIL rd_idx_ehi_asid: got %h want %h", {csr_wtlbidx, csr_wehi, csr_wasid}, {32'h0C00_0005, 19'h12345, 10'd3}); end
      vec++; if ({csr_welo0, csr_welo1} !== {32'h000A_BC1F, 32'h000A_BD11}) begin miss++; $display("FAIL rd_elo: got %h want %h", {csr_welo0, csr_welo1}, {32'h000A_BC1F, 32'h000A_BD11}); end
      csr_tlbidx = 32'h0C00_0009;
      begin_op(RD, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      vec++; if ({done, csr_we, csr_wtlbidx} !== {1'b1, 1'b1, 32'h8000_0009}) begin miss++; $display("FAIL rd_empty_idx: got %h want %h", {done, csr_we, csr_wtlbidx}, {1'b1, 1'b1, 32'h8000_0009}); end
      vec++; if ({csr_wehi, csr_welo0, csr_welo1, csr_wasid} !== '0) begin miss++; $display("FAIL rd_empty_zero: got %h want 0", {csr_wehi, csr_welo0, csr_welo1, csr_wasid}); end
   endtask

   task automatic test_fill();
      logic [3:0] exp_idx;
      csr_tlbidx = 32'h9600_0002; csr_tlbehi = 19'h0ABCD; csr_ecode = 6'h3F;
      csr_elo0 = 32'h0001_2347; csr_elo1 = 32'h0001_2443;
      begin_op(FILL, 5'd0, 10'd0, 19'd0);
      exp_idx = clk_cnt[3:0];
      vec++; if ({tlb_we, w_e, w_idx} !== {1'b1, 1'b1, exp_idx}) begin miss++; $display("FAIL fill_port: got %h want %h", {tlb_we, w_e, w_idx}, {1'b1, 1'b1, exp_idx}); end
      vec++; if ({w_ps, w_g, w_vppn} !== {6'd22, 1'b1, 19'h0ABCD}) begin miss++; $display("FAIL fill_fields: got %h want %h", {w_ps, w_g, w_vppn}, {6'd22, 1'b1, 19'h0ABCD}); end
      @(negedge clk);
      vec++; if ({done, csr_we} !== 2'b10) begin miss++; $display("FAIL fill_resp: got %b want 10", {done, csr_we}); end
      csr_ecode = 6'h00;
      begin_op(WR, 5'd0, 10'd0, 19'd0);
      vec++; if ({tlb_we, w_e, w_idx} !== {1'b1, 1'b0, 4'd2}) begin miss++; $display("FAIL wr_ne_port: got %h want %h", {tlb_we, w_e, w_idx}, {1'b1, 1'b0, 4'd2}); end
      @(negedge clk);
   endtask

   task automatic test_inv();
      begin_op(INV, 5'd5, 10'd3, 19'h12345);
      vec++; if ({inv_valid, inv_op, inv_asid, inv_vppn, tlb_we} !== {1'b1, 5'd5, 10'd3, 19'h12345, 1'b0}) begin miss++; $display("FAIL inv_port: got %h want %h", {inv_valid, inv_op, inv_asid, inv_vppn, tlb_we}, {1'b1, 5'd5, 10'd3, 19'h12345, 1'b0}); end
      @(negedge clk);
      vec++; if ({inv_valid, done, inv_err, csr_we} !== 4'b0100) begin miss++; $display("FAIL inv_resp: got %b want 0100", {inv_valid, done, inv_err, csr_we}); end
      begin_op(INV, 5'd7, 10'd3, 19'h12345);
      vec++; if (inv_valid !== 1'b0) begin miss++; $display("FAIL inv_bad_valid: got %h want 0", inv_valid); end
      @(negedge clk);
      vec++; if ({done, inv_err, inv_valid} !== 3'b110) begin miss++; $display("FAIL inv_bad_resp: got %b want 110", {done, inv_err, inv_valid}); end
      @(negedge clk);
      vec++; if ({done, inv_err} !== 2'b00) begin miss++; $display("FAIL inv_err_pulse: got %b want 00", {done, inv_err}); end
   endtask

   task automatic test_flush();
      csr_tlbidx = 32'h0C00_0005;
      begin_op(WR, 5'd0, 10'd0, 19'd0);
      flush = 1'b1;
      #1;
      vec++; if (tlb_we !== 1'b0) begin miss++; $display("FAIL flush_exec_we: got %h want 0", tlb_we); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      vec++; if ({done, csr_we, req_ready} !== 3'b001) begin miss++; $display("FAIL flush_exec_idle: got %b want 001", {done, csr_we, req_ready}); end
      begin_op(SRCH, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      flush = 1'b1;
      #1;
      vec++; if ({done, csr_we} !== 2'b00) begin miss++; $display("FAIL flush_resp: got %b want 00", {done, csr_we}); end
      @(negedge clk);
      flush = 1'b0;
      vec++; if (req_ready !== 1'b1) begin miss++; $display("FAIL flush_resp_idle: got %h want 1", req_ready); end
      // flush while idle must not block a same-cycle accept
      flush = 1'b1; req_valid = 1'b1; req_op = INV; req_invop = 5'd0; req_asid = 10'd1; req_vppn = 19'd0;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      #1;
      vec++; if ({req_ready, inv_valid} !== 2'b01) begin miss++; $display("FAIL flush_idle_accept: got %b want 01", {req_ready, inv_valid}); end
      @(negedge clk);
      vec++; if (done !== 1'b1) begin miss++; $display("FAIL flush_idle_done: got %h want 1", done); end
   endtask

   task automatic test_async_reset();
      begin_op(SRCH, 5'd0, 10'd0, 19'd0);
      @(negedge clk);
      vec++; if (done !== 1'b1) begin miss++; $display("FAIL arst_pre_done: got %h want 1", done); end
      #2 reset = 1'b1;
      #1;
      vec++; if ({done, csr_we, srch_act, req_ready} !== 4'b0001) begin miss++; $display("FAIL arst_resp: got %b want 0001", {done, csr_we, srch_act, req_ready}); end
      @(negedge clk);
      reset = 1'b0;
      csr_tlbidx = 32'h0C00_0006;
      begin_op(WR, 5'd0, 10'd0, 19'd0);
      #1 reset = 1'b1;
      #1;
      vec++; if (tlb_we !== 1'b0) begin miss++; $display("FAIL arst_exec_we: got %h want 0", tlb_we); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vec++; if ({tlb_we, done, req_ready} !== 3'b001) begin miss++; $display("FAIL arst_after: got %b want 001", {tlb_we, done, req_ready}); end
   endtask

   initial begin
      test_reset();
      test_write_search();
      test_search_miss();
      test_read();
      test_fill();
      test_inv();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
